// File: rtl/dot_product_loader_16_pkg.sv
// Shared linear-algebra constants and helpers
// for the 16-element dot-product datapath.
package dot_product_loader_16_pkg;

  localparam int LA_IN_WIDTH = 14;
  localparam int LA_VEC_LEN  = 16;
  localparam int LA_CNT_W    = $clog2(LA_VEC_LEN);

  typedef logic [LA_CNT_W-1:0] idx_t;

  localparam idx_t LA_LAST_IDX = idx_t'(LA_VEC_LEN - 1);
  localparam idx_t LA_ONE      = idx_t'(1);

  function automatic logic closes(
    input idx_t cnt,
    input logic last
  );
    return last || (cnt == LA_LAST_IDX);
  endfunction

endpackage

// File: rtl/dot_product_loader_16.sv
// Streams A/B element pairs into 16-slot vectors
// and presents them, zero padded, to the dot-product stage.
module dot_product_loader_16
  import dot_product_loader_16_pkg::*;
#(
  parameter int IN_WIDTH = LA_IN_WIDTH,
  parameter int VEC_LEN  = LA_VEC_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       inValid,
  input  logic signed [IN_WIDTH-1:0] inA,
  input  logic signed [IN_WIDTH-1:0] inB,
  input  logic                       inLast,
  output logic signed [IN_WIDTH-1:0] A0,
  output logic signed [IN_WIDTH-1:0] A1,
  output logic signed [IN_WIDTH-1:0] A2,
  output logic signed [IN_WIDTH-1:0] A3,
  output logic signed [IN_WIDTH-1:0] A4,
  output logic signed [IN_WIDTH-1:0] A5,
  output logic signed [IN_WIDTH-1:0] A6,
  output logic signed [IN_WIDTH-1:0] A7,
  output logic signed [IN_WIDTH-1:0] A8,
  output logic signed [IN_WIDTH-1:0] A9,
  output logic signed [IN_WIDTH-1:0] A10,
  output logic signed [IN_WIDTH-1:0] A11,
  output logic signed [IN_WIDTH-1:0] A12,
  output logic signed [IN_WIDTH-1:0] A13,
  output logic signed [IN_WIDTH-1:0] A14,
  output logic signed [IN_WIDTH-1:0] A15,
  output logic signed [IN_WIDTH-1:0] B0,
  output logic signed [IN_WIDTH-1:0] B1,
  output logic signed [IN_WIDTH-1:0] B2,
  output logic signed [IN_WIDTH-1:0] B3,
  output logic signed [IN_WIDTH-1:0] B4,
  output logic signed [IN_WIDTH-1:0] B5,
  output logic signed [IN_WIDTH-1:0] B6,
  output logic signed [IN_WIDTH-1:0] B7,
  output logic signed [IN_WIDTH-1:0] B8,
  output logic signed [IN_WIDTH-1:0] B9,
  output logic signed [IN_WIDTH-1:0] B10,
  output logic signed [IN_WIDTH-1:0] B11,
  output logic signed [IN_WIDTH-1:0] B12,
  output logic signed [IN_WIDTH-1:0] B13,
  output logic signed [IN_WIDTH-1:0] B14,
  output logic signed [IN_WIDTH-1:0] B15,
  output logic                       outReady,
  output logic [3:0]                 elemCount
);

  typedef logic signed [IN_WIDTH-1:0] elem_t;

  elem_t slot_a [VEC_LEN];
  elem_t slot_b [VEC_LEN];
  elem_t vec_a  [VEC_LEN];
  elem_t vec_b  [VEC_LEN];

  idx_t cnt;
  logic ready_q;
  logic take;
  logic close;

  assign take  = enable && inValid;
  assign close = take && closes(cnt, inLast);

  // outReady is only recomputed on enabled edges,
  // so a pulse stretches while the pipeline is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      ready_q <= 1'b0;
    end else if (enable) begin
      ready_q <= close;
      if (close) begin
        cnt <= '0;
      end else if (take) begin
        cnt <= cnt + LA_ONE;
      end
    end
  end

  for (genvar g = 0; g < VEC_LEN; g++) begin : g_slot
    localparam idx_t IDX = idx_t'(g);

    logic hit;
    logic filled;

    assign hit    = (cnt == IDX);
    assign filled = (cnt > IDX);

    // Slots past the closing index load zero so the
    // downstream products for them vanish.
    always_ff @(posedge clk) begin
      if (reset) begin
        slot_a[g] <= '0;
        slot_b[g] <= '0;
        vec_a[g]  <= '0;
        vec_b[g]  <= '0;
      end else if (close) begin
        slot_a[g] <= '0;
        slot_b[g] <= '0;
        if (filled) begin
          vec_a[g] <= slot_a[g];
          vec_b[g] <= slot_b[g];
        end else if (hit) begin
          vec_a[g] <= inA;
          vec_b[g] <= inB;
        end else begin
          vec_a[g] <= '0;
          vec_b[g] <= '0;
        end
      end else if (take && hit) begin
        slot_a[g] <= inA;
        slot_b[g] <= inB;
      end
    end
  end

  assign outReady  = ready_q;
  assign elemCount = cnt;

  assign A0  = vec_a[0];
  assign A1  = vec_a[1];
  assign A2  = vec_a[2];
  assign A3  = vec_a[3];
  assign A4  = vec_a[4];
  assign A5  = vec_a[5];
  assign A6  = vec_a[6];
  assign A7  = vec_a[7];
  assign A8  = vec_a[8];
  assign A9  = vec_a[9];
  assign A10 = vec_a[10];
  assign A11 = vec_a[11];
  assign A12 = vec_a[12];
  assign A13 = vec_a[13];
  assign A14 = vec_a[14];
  assign A15 = vec_a[15];

  assign B0  = vec_b[0];
  assign B1  = vec_b[1];
  assign B2  = vec_b[2];
  assign B3  = vec_b[3];
  assign B4  = vec_b[4];
  assign B5  = vec_b[5];
  assign B6  = vec_b[6];
  assign B7  = vec_b[7];
  assign B8  = vec_b[8];
  assign B9  = vec_b[9];
  assign B10 = vec_b[10];
  assign B11 = vec_b[11];
  assign B12 = vec_b[12];
  assign B13 = vec_b[13];
  assign B14 = vec_b[14];
  assign B15 = vec_b[15];

endmodule

// File: doc/dot_product_loader_16.md
DOT_PRODUCT_LOADER_16 -- requirements
Module: dot_product_loader_16

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 14, signed element width; must match the downstream 16-element dot-product stage.
REQ-002 SHALL have parameter VEC_LEN, default 16, elements per vector; fixed at 16, no other value supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port enable, input, 1, global clock-enable; low freezes all state.
REQ-006 SHALL have port inValid, input, 1, element pair on inA/inB valid this cycle.
REQ-007 SHALL have port inA, input, IN_WIDTH signed, streamed A element.
REQ-008 SHALL have port inB, input, IN_WIDTH signed, streamed B element.
REQ-009 SHALL have port inLast, input, 1, qualifies inValid: current pair closes the vector early.
REQ-010 SHALL have ports A0..A15, output, IN_WIDTH signed each, assembled A vector; feeds the dot-product A0..A15 inputs.
REQ-011 SHALL have ports B0..B15, output, IN_WIDTH signed each, assembled B vector.
REQ-012 SHALL have port outReady, output, 1, one-cycle pulse marking a new vector on A*/B*; drives the dot-product inReady.
REQ-013 SHALL have port elemCount, output, 4, number of elements already collected for the current vector (0..15).

Function
REQ-014 SHALL accept an element pair at a rising edge iff enable=1 and inValid=1; write it into collection slot elemCount; then increment elemCount.
REQ-015 Element order SHALL be: first accepted pair goes to slot 0 (A0/B0), the 16th goes to slot 15.
REQ-016 Vector SHALL close at the accepting edge when elemCount=15 or inLast=1.
REQ-017 At the closing edge, A0..A15/B0..B15 SHALL load the collection slots including the current pair; slots above the current index SHALL load 0 (zero padding, so the dot product is unaffected).
REQ-018 At the closing edge, outReady SHALL be registered to 1 for exactly the following cycle, elemCount SHALL go to 0, and collection slots SHALL clear to 0.
REQ-019 Latency: outReady SHALL be high in the cycle immediately after the closing pair is presented; the block SHALL have no stall and SHALL accept one pair every cycle, back-to-back vectors included.
REQ-020 A0..A15/B0..B15 SHALL hold their value until the next closing edge; they SHALL be stable whenever outReady=1.
REQ-021 inLast with inValid=0 SHALL be ignored; inLast at elemCount=0 SHALL produce a vector with only slot 0 nonzero.
REQ-022 With enable=0, all registers including outReady and elemCount SHALL hold; an outReady pulse SHALL stretch across disabled cycles, matching the downstream stage, which is frozen by the same enable.
REQ-023 No arithmetic is performed; values SHALL pass bit-exact with no sign extension or truncation.

Reset
REQ-024 With reset=1 at an edge, reset SHALL take priority over enable and inValid; outReady=0, elemCount=0, and all slots and A*/B* outputs SHALL be 0.
REQ-025 Reset mid-vector SHALL discard the partial vector and emit no outReady; the first pair accepted after reset SHALL go to slot 0.

Structure
REQ-026 IN_WIDTH default and VEC_LEN=16 constants SHALL live in the shared linear-algebra package.
REQ-027 No sub-module SHALL be used: one counter, 16 collection slot pairs with decoded write, and the output register bank.

Verification
REQ-028 Stream 16 pairs Ak=k+1, Bk=-(k+1) back-to-back -> one outReady pulse in the cycle after pair 15; A5=6, B5=-6; elemCount returns to 0.
REQ-029 Send 5 pairs with inLast on the 5th (A=B=3) -> outReady pulse; A0..A4=3, A5..A15=0 and B5..B15=0; downstream DP=45.
REQ-030 Send two full vectors with no gap -> two outReady pulses exactly 16 cycles apart, and the second vector's values are correct.
REQ-031 Send 7 pairs, assert reset for 1 cycle, then send 16 pairs of value 2 -> exactly one outReady pulse; all A*=B*=2.
REQ-032 Hold enable=0 for 3 cycles mid-vector and during the outReady cycle -> no pair accepted; elemCount is frozen; the outReady pulse lasts 4 cycles; outputs are unchanged.
REQ-033 Present inValid=1 with inA=-8192, inB=8191 (IN_WIDTH=14 extremes) in slot 15 -> A15=-8192 and B15=8191, bit-exact.
